// File: rtl/memory_write_sequencer.sv
// memory_write_sequencer: decodes framed configuration bytes (start address,
// word count, little-endian payload) into single-cycle writes on the parameter
// memory port, with address auto-increment and wrap at M-1.
module memory_write_sequencer #(
    parameter int M = 10,
    parameter int N = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               frame_sync,
    input  logic [7:0]                         byte_in,
    input  logic                               byte_valid,
    output logic [N-1:0]                       mem_data,
    output logic [((M > 1) ? $clog2(M) : 1)-1:0] mem_addr,
    output logic                               mem_we,
    output logic                               busy,
    output logic                               done,
    output logic                               err
);
    localparam int AW  = (M > 1) ? $clog2(M) : 1;
    localparam int BPW = (N + 7) / 8;
    localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [2:0] {IDLE, HDR_ADDR, HDR_CNT, PAYLOAD, DRAIN} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] addr_cnt;
    logic [7:0]    remain;
    logic [BW-1:0] byte_idx;
    logic [N-1:0]  asm_q, asm_nx;
    logic          addr_bad, word_end;

    // Header address check and end-of-word detection.
    always_comb begin
        addr_bad = ({24'd0, byte_in} >= 32'(M));
        word_end = (byte_idx == BW'(BPW - 1));
    end

    // Merge the incoming byte into the assembly word at its little-endian
    // position; bits beyond N simply have no destination.
    always_comb begin
        asm_nx = asm_q;
        for (int b = 0; b < N; b++) begin
            if (byte_idx == BW'(b / 8))
                asm_nx[b] = byte_in[b % 8];
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic; frame_sync overrides any byte in the same cycle.
    always_comb begin
        state_nx = state;
        if (frame_sync) begin
            state_nx = HDR_ADDR;
        end else if (byte_valid) begin
            case (state)
                HDR_ADDR: state_nx = addr_bad ? DRAIN : HDR_CNT;
                HDR_CNT:  state_nx = (byte_in == 8'd0) ? IDLE : PAYLOAD;
                PAYLOAD:  if (word_end && remain == 8'd1) state_nx = IDLE;
                default:  state_nx = state;
            endcase
        end
    end

    // Busy covers header and payload; DRAIN and IDLE are quiet.
    always_comb begin
        busy = (state == HDR_ADDR) || (state == HDR_CNT) || (state == PAYLOAD);
    end

    // Datapath: counters, word assembly and registered write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_cnt <= '0;
            remain   <= '0;
            byte_idx <= '0;
            asm_q    <= '0;
            mem_data <= '0;
            mem_addr <= '0;
            mem_we   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            if (frame_sync) begin
                err      <= 1'b0;
                byte_idx <= '0;
            end else if (byte_valid) begin
                case (state)
                    HDR_ADDR: begin
                        if (addr_bad) err <= 1'b1;
                        else          addr_cnt <= byte_in[AW-1:0];
                    end
                    HDR_CNT: begin
                        if (byte_in == 8'd0) begin
                            done <= 1'b1;
                        end else begin
                            remain   <= byte_in;
                            byte_idx <= '0;
                        end
                    end
                    PAYLOAD: begin
                        asm_q <= asm_nx;
                        if (word_end) begin
                            mem_we   <= 1'b1;
                            mem_addr <= addr_cnt;
                            mem_data <= asm_nx;
                            byte_idx <= '0;
                            remain   <= remain - 8'd1;
                            addr_cnt <= (addr_cnt == AW'(M - 1)) ? '0 : addr_cnt + AW'(1);
                            if (remain == 8'd1) done <= 1'b1;
                        end else begin
                            byte_idx <= byte_idx + BW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_memory_write_sequencer.sv
// Bench for memory_write_sequencer: two instances (N=8 and N=12) share one
// byte stream; a frame-interpreter model predicts every output each cycle.
module tb_memory_write_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_sync = 1'b0;
    logic [7:0] byte_in = 8'd0;
    logic       byte_valid = 1'b0;

    logic [7:0]  data8;
    logic [11:0] data12;
    logic [3:0]  addr8, addr12;
    logic        we8, we12, busy8, busy12, done8, done12, err8, err12;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    memory_write_sequencer #(.M(10), .N(8)) dut8 (
        .clk(clk), .reset(reset), .frame_sync(frame_sync), .byte_in(byte_in),
        .byte_valid(byte_valid), .mem_data(data8), .mem_addr(addr8), .mem_we(we8),
        .busy(busy8), .done(done8), .err(err8));

    memory_write_sequencer #(.M(10), .N(12)) dut12 (
        .clk(clk), .reset(reset), .frame_sync(frame_sync), .byte_in(byte_in),
        .byte_valid(byte_valid), .mem_data(data12), .mem_addr(addr12), .mem_we(we12),
        .busy(busy12), .done(done12), .err(err12));

    // Model state per instance: phase 0 idle,1 addr,2 count,3 payload,4 drain.
    int ph[2], addr[2], rem[2], nb[2], acc[2];
    int e_we[2], e_done[2], e_err[2], e_addr[2], e_data[2];
    int bpw[2]  = '{1, 2};
    int mask[2] = '{'hFF, 'hFFF};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t obs=%h exp=%h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            ph[d] = 0; addr[d] = 0; rem[d] = 0; nb[d] = 0; acc[d] = 0;
            e_we[d] = 0; e_done[d] = 0; e_err[d] = 0; e_addr[d] = 0; e_data[d] = 0;
        end
    endtask

    task automatic model_step(input bit fs, input bit bv, input int b);
        for (int d = 0; d < 2; d++) begin
            e_we[d] = 0; e_done[d] = 0;
            if (fs) begin
                ph[d] = 1; e_err[d] = 0; nb[d] = 0; acc[d] = 0;
            end else if (bv) begin
                case (ph[d])
                    1: if (b >= 10) begin e_err[d] = 1; ph[d] = 4; end
                       else begin addr[d] = b; ph[d] = 2; end
                    2: if (b == 0) begin e_done[d] = 1; ph[d] = 0; end
                       else begin rem[d] = b; nb[d] = 0; acc[d] = 0; ph[d] = 3; end
                    3: begin
                        acc[d] += b << (8 * nb[d]);
                        nb[d]++;
                        if (nb[d] == bpw[d]) begin
                            e_we[d] = 1; e_addr[d] = addr[d]; e_data[d] = acc[d] & mask[d];
                            addr[d] = (addr[d] + 1) % 10;
                            rem[d]--; nb[d] = 0; acc[d] = 0;
                            if (rem[d] == 0) begin e_done[d] = 1; ph[d] = 0; end
                        end
                    end
                    default: ;
                endcase
            end
        end
    endtask

    function automatic logic [31:0] pack(int we, int dn, int bs, int er, int a, int dt);
        return {8'd0, 1'(we), 1'(dn), 1'(bs), 1'(er), 4'(a), 16'(dt)};
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "/n8"},  pack(we8, done8, busy8, err8, addr8, data8),
            pack(e_we[0], e_done[0], ph[0] >= 1 && ph[0] <= 3, e_err[0], e_addr[0], e_data[0]));
        chk({tag, "/n12"}, pack(we12, done12, busy12, err12, addr12, data12),
            pack(e_we[1], e_done[1], ph[1] >= 1 && ph[1] <= 3, e_err[1], e_addr[1], e_data[1]));
    endtask

    task automatic cyc(input string tag, input bit fs, input bit bv, input int b);
        @(negedge clk);
        frame_sync = fs; byte_valid = bv; byte_in = 8'(b);
        @(posedge clk);
        model_step(fs, bv, b);
        #1 check_all(tag);
    endtask

    task automatic frame(input string tag, input int bytes[$]);
        cyc(tag, 1'b1, 1'b0, 0);
        foreach (bytes[i]) cyc(tag, 1'b0, 1'b1, bytes[i]);
        cyc(tag, 1'b0, 1'b0, 0);
        cyc(tag, 1'b0, 1'b0, 0);
    endtask

    initial begin
        model_reset();
        #1 check_all("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        frame("basic", '{'h02, 'h03, 'hAA, 'hBB, 'hCC});
        frame("wrap",  '{'h08, 'h04, 'h11, 'h22, 'h33, 'h44});
        frame("badaddr", '{'h0A, 'h01, 'h55});
        cyc("badclr", 1'b1, 1'b0, 0);
        frame("n12", '{'h00, 'h02, 'h34, 'h12, 'hFF, 'h0F});

        // Abort: sync arrives with a valid byte that must be discarded.
        cyc("abort", 1'b1, 1'b0, 0);
        cyc("abort", 1'b0, 1'b1, 'h01);
        cyc("abort", 1'b0, 1'b1, 'h02);
        cyc("abort", 1'b0, 1'b1, 'h77);
        cyc("abort", 1'b1, 1'b1, 'h66);
        cyc("abort", 1'b0, 1'b1, 'h05);
        cyc("abort", 1'b0, 1'b1, 'h01);
        cyc("abort", 1'b0, 1'b1, 'h99);
        cyc("abort", 1'b0, 1'b1, 'h98);
        cyc("abort", 1'b0, 1'b0, 0);

        // Reset between payload bytes: outputs clear without a clock edge.
        cyc("midrst", 1'b1, 1'b0, 0);
        cyc("midrst", 1'b0, 1'b1, 'h01);
        cyc("midrst", 1'b0, 1'b1, 'h05);
        cyc("midrst", 1'b0, 1'b1, 'hAB);
        @(negedge clk);
        byte_valid = 1'b0;
        reset = 1'b1;
        model_reset();
        #1 check_all("asyncrst");
        @(posedge clk);
        #1 check_all("rsthold");
        @(negedge clk) reset = 1'b0;
        frame("cnt0", '{'h03, 'h00});

        // Random stream with gaps, aborts and mostly small header values.
        for (int i = 0; i < 3000; i++) begin
            bit fs;
            bit bv;
            int b;
            fs = ($urandom_range(0, 24) == 0);
            bv = ($urandom_range(0, 3) != 0);
            b  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 12) : $urandom_range(0, 255);
            cyc("rand", fs, bv, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
